// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared types and defaults for the key debounce scheduler.
//   state_t          : scheduler FSM state (IDLE, TIMING)
//   DEF_N_KEYS       : default number of keys
//   DEF_DEBOUNCE_CNT : default debounce length in clk cycles (30 ms at 50 MHz)
//   DEF_CNT_W        : default shared timer width
//   GLITCH_W         : width of the optional abort counter
package key_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    TIMING = 1'b1
  } state_t;

  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_DEBOUNCE_CNT = 1500000;
  localparam int DEF_CNT_W        = 21;
  localparam int GLITCH_W         = 8;

endpackage

// File: rtl/key_rr_pick.sv
// key_rr_pick: combinational rotating-priority picker.
// Returns the first set request bit found searching upward from rr_ptr,
// wrapping past N_KEYS-1 back to 0.
// Ports:
//   req       in  N_KEYS  request vector
//   rr_ptr    in  IDX_W   index with highest priority (must be < N_KEYS)
//   gnt_valid out 1       at least one request set
//   gnt_idx   out IDX_W   granted index (0 when gnt_valid is low)
module key_rr_pick
  import key_sched_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS,
  parameter int IDX_W  = 2
) (
  input  logic [N_KEYS-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx
);

  int               j;
  logic [IDX_W-1:0] jidx;

  // Walk offsets from the far end down to offset 0 so the nearest request
  // to rr_ptr is the last one written and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    jidx      = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      jidx = IDX_W'(j);
      if (req[jidx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = jidx;
      end
    end
  end

endmodule

// File: rtl/key_debounce_sched.sv
// key_debounce_sched: debounces N_KEYS push-buttons with one shared timer.
// A round-robin picker grants the timer to one key whose synchronized level
// differs from its committed level; on expiry the level is committed and a
// one-cycle press/release pulse is emitted.
// Optional: define KEY_GLITCH_CNT_EN to add glitch_cnt, a saturating count
// of checks abandoned because the key reverted before expiry.
// Ports:
//   clk         in  1       system clock (50 MHz)
//   reset_n     in  1       synchronous active-low reset
//   key         in  N_KEYS  raw asynchronous key levels, 1 = pressed
//   key_state   out N_KEYS  debounced level per key
//   key_press   out N_KEYS  one-cycle pulse on committed 0->1
//   key_release out N_KEYS  one-cycle pulse on committed 1->0
//   busy        out 1       timer granted (TIMING)
//   active_idx  out IDX_W   granted key, holds last grant when idle
//   glitch_cnt  out 8       abort count (KEY_GLITCH_CNT_EN only)
//
// state  | meaning
// IDLE   | no key under test; grant next mismatching key if any
// TIMING | timer owned by active_idx; abort on revert, commit on expiry
module key_debounce_sched
  import key_sched_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int IDX_W        = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_KEYS-1:0]   key,
  output logic [N_KEYS-1:0]   key_state,
  output logic [N_KEYS-1:0]   key_press,
  output logic [N_KEYS-1:0]   key_release,
  output logic                busy,
  output logic [IDX_W-1:0]    active_idx
`ifdef KEY_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_KEYS - 1);

  logic [N_KEYS-1:0] key_s1;
  logic [N_KEYS-1:0] ks;
  logic [N_KEYS-1:0] mismatch;
  logic [CNT_W-1:0]  timer;
  logic [IDX_W-1:0]  rr_ptr;
  state_t            state;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;

  assign mismatch = ks ^ key_state;

  key_rr_pick #(
    .N_KEYS (N_KEYS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (mismatch),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_s1 <= '0;
      ks     <= '0;
    end else begin
      key_s1 <= key;
      ks     <= key_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      rr_ptr      <= '0;
      active_idx  <= '0;
      busy        <= 1'b0;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
`ifdef KEY_GLITCH_CNT_EN
      glitch_cnt  <= '0;
`endif
    end else begin
      key_press   <= '0;
      key_release <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            active_idx <= gnt_idx;
            rr_ptr     <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            timer      <= '0;
            busy       <= 1'b1;
            state      <= TIMING;
          end
        end
        TIMING: begin
          // A revert wins over expiry so a key bouncing on the last cycle
          // is never committed.
          if (!mismatch[active_idx]) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef KEY_GLITCH_CNT_EN
            if (glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
`endif
          end else if (timer == TIMER_LAST) begin
            key_state[active_idx]   <= ks[active_idx];
            key_press[active_idx]   <= ks[active_idx];
            key_release[active_idx] <= ~ks[active_idx];
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_sched.sv
// tb_key_debounce_sched: directed bench for key_debounce_sched with
// N_KEYS=4, DEBOUNCE_CNT=8. Each scenario logs outputs per cycle; log index
// i holds the outputs sampled just after the (i+1)-th edge of the scenario.
// A key driven before edge 1 is synchronized at edge 2, granted at edge 3
// (index 2) and committed at edge 11 (index 10).
module tb_key_debounce_sched;

  logic       clk;
  logic       reset_n;
  logic [3:0] key;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       busy;
  logic [1:0] active_idx;
`ifdef KEY_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lp = 0;
  int multi_hits = 0;

  logic [3:0] press_log [0:63];
  logic [3:0] rel_log   [0:63];
  logic       busy_log  [0:63];
  logic [1:0] idx_log   [0:63];

  key_debounce_sched #(
    .N_KEYS       (4),
    .DEBOUNCE_CNT (8),
    .CNT_W        (4),
    .IDX_W        (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key         (key),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .busy        (busy),
    .active_idx  (active_idx)
`ifdef KEY_GLITCH_CNT_EN
    ,
    .glitch_cnt  (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] k, input logic rn);
    key     = k;
    reset_n = rn;
    @(posedge clk);
    #1;
    if (lp < 64) begin
      press_log[lp] = key_press;
      rel_log[lp]   = key_release;
      busy_log[lp]  = busy;
      idx_log[lp]   = active_idx;
      lp++;
    end
    if ($countones(key_press | key_release) > 1) multi_hits++;
  endtask

  function automatic int first_evt(input bit rel, input int b);
    for (int i = 0; i < lp; i++)
      if (rel ? rel_log[i][b] : press_log[i][b]) return i;
    return -1;
  endfunction

  function automatic int evt_cnt(input bit rel);
    int n = 0;
    for (int i = 0; i < lp; i++)
      n += rel ? $countones(rel_log[i]) : $countones(press_log[i]);
    return n;
  endfunction

  function automatic int busy_cnt();
    int n = 0;
    for (int i = 0; i < lp; i++) if (busy_log[i]) n++;
    return n;
  endfunction

  function automatic int first_busy();
    for (int i = 0; i < lp; i++) if (busy_log[i]) return i;
    return -1;
  endfunction

  initial begin
    key     = '0;
    reset_n = 1'b0;
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("rst_state",   key_state,   0);
    chk("rst_press",   key_press,   0);
    chk("rst_release", key_release, 0);
    chk("rst_busy",    busy,        0);
    chk("rst_idx",     active_idx,  0);
`ifdef KEY_GLITCH_CNT_EN
    chk("rst_glitch",  glitch_cnt,  0);
`endif
    step(4'b0000, 1'b1);

    // 1. clean press of key 1
    lp = 0;
    repeat (20) step(4'b0010, 1'b1);
    chk("t1_press_at",  first_evt(0, 1), 10);
    chk("t1_press_n",   evt_cnt(0),      1);
    chk("t1_rel_n",     evt_cnt(1),      0);
    chk("t1_busy_n",    busy_cnt(),      8);
    chk("t1_grant_at",  first_busy(),    2);
    chk("t1_grant_idx", idx_log[2],      1);
    chk("t1_state",     key_state,       4'b0010);

    // 2. bounce on key 0: 1,0,1 in 3-cycle chunks, then hold
    lp = 0;
    for (int i = 0; i < 22; i++)
      step((i < 3 || i >= 6) ? 4'b0011 : 4'b0010, 1'b1);
    chk("t2_grant_at", first_busy(),    2);
    chk("t2_aborted",  busy_log[5],     0);
    chk("t2_press_at", first_evt(0, 0), 16);
    chk("t2_press_n",  evt_cnt(0),      1);
    chk("t2_busy_n",   busy_cnt(),      11);
    chk("t2_state",    key_state,       4'b0011);
`ifdef KEY_GLITCH_CNT_EN
    chk("t2_glitch",   glitch_cnt,      1);
`endif

    // reset to put rr_ptr back at 0
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("r2_state", key_state,  0);
    chk("r2_busy",  busy,       0);
`ifdef KEY_GLITCH_CNT_EN
    chk("r2_glitch", glitch_cnt, 0);
`endif
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // 3. contention: keys 0, 2, 3 rise together
    lp = 0;
    repeat (32) step(4'b1101, 1'b1);
    chk("t3_first",  press_log[10], 4'b0001);
    chk("t3_second", press_log[19], 4'b0100);
    chk("t3_third",  press_log[28], 4'b1000);
    chk("t3_press_n", evt_cnt(0),   3);
    chk("t3_state",  key_state,     4'b1101);

    // rr_ptr back at 0: key 0 release is served before key 1 press
    lp = 0;
    repeat (22) step(4'b1110, 1'b1);
    chk("t3b_rel0",   rel_log[10],   4'b0001);
    chk("t3b_press1", press_log[19], 4'b0010);
    chk("t3b_state",  key_state,     4'b1110);

    // 5. release of key 2 (rr_ptr=2)
    lp = 0;
    repeat (14) step(4'b1010, 1'b1);
    chk("t5_rel_at",  first_evt(1, 2), 10);
    chk("t5_rel_n",   evt_cnt(1),      1);
    chk("t5_press_n", evt_cnt(0),      0);
    chk("t5_state",   key_state,       4'b1010);

    // 4. wrap: rr_ptr=3, keys 3 and 1 pending
    lp = 0;
    repeat (22) step(4'b0000, 1'b1);
    chk("t4_idx_first",  idx_log[2],  3);
    chk("t4_rel_first",  rel_log[10], 4'b1000);
    chk("t4_idx_second", idx_log[11], 1);
    chk("t4_rel_second", rel_log[19], 4'b0010);
    chk("t4_state",      key_state,   4'b0000);

    // 6. reset during TIMING at timer=4 on key 2
    lp = 0;
    for (int i = 0; i < 22; i++) step(4'b0100, (i == 7) ? 1'b0 : 1'b1);
    chk("t6_busy_pre",  busy_log[6],     1);
    chk("t6_idx_pre",   idx_log[6],      2);
    chk("t6_busy_rst",  busy_log[7],     0);
    chk("t6_idx_rst",   idx_log[7],      0);
    chk("t6_press_at",  first_evt(0, 2), 18);
    chk("t6_press_n",   evt_cnt(0),      1);
    chk("t6_busy_n",    busy_cnt(),      13);
    chk("t6_state",     key_state,       4'b0100);

    chk("one_hot_events", multi_hits, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_sched.md
Name: key_debounce_sched

Overview:
- Debounces N_KEYS raw push-buttons with one shared debounce timer instead of one counter per key.
- A round-robin scheduler grants the timer to one key whose synchronized input differs from its stable state.
- When the timer expires, that key's stable state is committed and a one-cycle press/release event is emitted.
- Sits between board key pins and the downstream control/display logic of the 50 MHz design.

Parameters:
N_KEYS, 4, number of keys (2..16)
DEBOUNCE_CNT, 1500000, timer length in clk cycles (30 ms at 50 MHz); legal range 2..2^CNT_W
CNT_W, 21, shared timer width
IDX_W, 2, width of key index; must equal clog2(N_KEYS)

Ports:
clk  input  1  50 MHz system clock
reset_n  input  1  synchronous active-low reset, sampled on rising clk
key  input  N_KEYS  raw asynchronous key levels, 1 = pressed
key_state  output  N_KEYS  debounced stable level per key
key_press  output  N_KEYS  one-cycle pulse on committed 0->1
key_release  output  N_KEYS  one-cycle pulse on committed 1->0
busy  output  1  high while the timer is granted (TIMING state)
active_idx  output  IDX_W  index of granted key; holds last grant when idle
glitch_cnt  output  8  only present with KEY_GLITCH_CNT_EN (see below)

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all of the following. Reset mid-TIMING abandons the check with no event.
  - Outputs: key_state=0, key_press=0, key_release=0, busy=0, active_idx=0.
  - Internal: sync flops=0, timer=0, rr_ptr=0, state=IDLE.
- Input sync: each key passes through 2 flops giving ks[i]. Define mismatch[i] = ks[i] ^ key_state[i].
- FSM states, encoded in the package: IDLE, TIMING.
- IDLE:
  - If mismatch != 0, pick the first set bit searching upward from rr_ptr with wrap.
  - Next edge: active_idx=g, rr_ptr=(g+1) mod N_KEYS, timer=0, state=TIMING, busy=1.
  - If mismatch == 0: hold.
- TIMING:
  - Abort: if mismatch[active_idx]==0, go to IDLE next edge, timer=0, no event.
  - Expiry: at the cycle where timer==DEBOUNCE_CNT-1 and mismatch[active_idx]==1, the next edge does all of:
    - key_state[active_idx] <= ks[active_idx];
    - pulse key_press or key_release for that bit, high for exactly one cycle;
    - go to IDLE.
  - Otherwise timer increments by 1. The timer never exceeds DEBOUNCE_CNT-1.
  - Abort takes priority over expiry in the same cycle.
- Latency: with the mismatch first seen in IDLE at edge T, the grant occurs at T+1 and the commit/pulse at T+1+DEBOUNCE_CNT. Add 2 cycles for sync from the pin.
- Fairness: changes on non-granted keys are only observed, never lost, while they persist. The worst-case wait before a key is granted is (N_KEYS-1)*(DEBOUNCE_CNT+1) cycles.
- After any commit or abort, the scheduler spends one IDLE cycle before the next grant.
- A key pressed and released entirely while another key holds the timer produces no event; this is acceptable by design.
- Multiple keys never commit in the same cycle; at most one bit of key_press|key_release is set.

Optional Feature:
- Macro: KEY_GLITCH_CNT_EN.
- Defined: glitch_cnt port exists; an 8-bit saturating counter (stops at 255) increments on every TIMING abort and is cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package key_sched_pkg holds:
  - state enum (IDLE, TIMING);
  - default DEBOUNCE_CNT, CNT_W, N_KEYS;
  - glitch counter width 8.
- Sub-module key_rr_pick: combinational rotating-priority picker.
  - Inputs: req[N_KEYS], rr_ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Unit-tested separately.
- The top contains the sync flops, FSM, timer, state/event registers and the optional glitch counter.

Test Plan:
(Bench overrides N_KEYS=4, DEBOUNCE_CNT=8.)
1. Clean press: key[1] 0->1 held -> key_press[1] pulses one cycle exactly 1+8 cycles after the mismatch appears in IDLE; key_state=4'b0010; busy high 8 cycles.
2. Bounce: key[0] toggles 1,0,1 every 3 cycles then holds 1 -> the first grant aborts (glitch_cnt=1 with KEY_GLITCH_CNT_EN); a later grant commits; a single key_press[0].
3. Contention: key[0], key[2], key[3] rise in the same cycle with rr_ptr=0 -> commit order 0, 2, 3, each commit 9 cycles apart; rr_ptr ends at 0.
4. Round-robin wrap: rr_ptr=3 with key[3] and key[1] pending -> key 3 granted first, then key 1.
5. Release: key_state[2]=1, key[2] falls and holds -> key_release[2] one-cycle pulse; key_state[2]=0; no key_press activity.
6. Reset mid-TIMING: reset_n low for 1 cycle at timer=4 -> all outputs 0, timer=0, no pulse; with key still pressed, a fresh 9-cycle check then key_press.
